// File: rtl/axicb_slv_mr_cpl.sv
// Misrouted-request completion generator: acts as a virtual slave that answers
// a decode-miss request with DECERR (len+1 read beats, or one write response).
module axicb_slv_mr_cpl #(
    parameter int RD_PATH    = 0,
    parameter int AXI_ID_W   = 8,
    parameter int AXI_DATA_W = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [7:0]            req_len,
    input  logic [AXI_ID_W-1:0]   req_id,
    output logic                  cpl_valid,
    input  logic                  cpl_ready,
    output logic                  cpl_last,
    output logic [AXI_ID_W-1:0]   cpl_id,
    output logic [1:0]            cpl_resp,
    output logic [AXI_DATA_W-1:0] cpl_data
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t     state;
    logic [7:0] cnt;

    // Beat count and last-flag loaded on acceptance; write path is always one beat.
    logic [7:0] load_cnt;
    logic       load_last;

    assign load_cnt  = (RD_PATH != 0) ? req_len : 8'd0;
    assign load_last = (load_cnt == 8'd0);

    assign req_ready = (state == IDLE) | ((state == BURST) & cpl_ready & (cnt == 8'd0));
    assign cpl_resp  = 2'b11;
    assign cpl_data  = '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            cpl_id    <= '0;
            cpl_valid <= 1'b0;
            cpl_last  <= 1'b0;
        end else if (srst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            cpl_id    <= '0;
            cpl_valid <= 1'b0;
            cpl_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= BURST;
                        cnt       <= load_cnt;
                        cpl_id    <= req_id;
                        cpl_valid <= 1'b1;
                        cpl_last  <= load_last;
                    end
                end
                BURST: begin
                    if (cpl_ready) begin
                        if (cnt != 8'd0) begin
                            cnt      <= cnt - 8'd1;
                            cpl_last <= (cnt == 8'd1);
                        end else if (req_valid) begin
                            // Back-to-back: next request reloads without a bubble.
                            cnt      <= load_cnt;
                            cpl_id   <= req_id;
                            cpl_last <= load_last;
                        end else begin
                            state     <= IDLE;
                            cpl_valid <= 1'b0;
                            cpl_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cpl_valid <= 1'b0;
                    cpl_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axicb_slv_mr_cpl.sv
// Directed bench for axicb_slv_mr_cpl: a read-path and a write-path instance
// sharing clock, resets and cpl_ready.
module tb_axicb_slv_mr_cpl;

    logic       aclk = 1'b0;
    logic       aresetn, srst, cpl_ready;
    logic       req_valid, w_req_valid;
    logic [7:0] req_len, w_req_len, req_id, w_req_id;
    logic       req_ready, w_req_ready;
    logic       cpl_valid, w_cpl_valid, cpl_last, w_cpl_last;
    logic [7:0] cpl_id, w_cpl_id, cpl_data, w_cpl_data;
    logic [1:0] cpl_resp, w_cpl_resp;

    int errs = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    axicb_slv_mr_cpl #(.RD_PATH(1), .AXI_ID_W(8), .AXI_DATA_W(8)) u_rd (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len), .req_id(req_id),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_last(cpl_last),
        .cpl_id(cpl_id), .cpl_resp(cpl_resp), .cpl_data(cpl_data)
    );

    axicb_slv_mr_cpl #(.RD_PATH(0), .AXI_ID_W(8), .AXI_DATA_W(8)) u_wr (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_len(w_req_len), .req_id(w_req_id),
        .cpl_valid(w_cpl_valid), .cpl_ready(cpl_ready), .cpl_last(w_cpl_last),
        .cpl_id(w_cpl_id), .cpl_resp(w_cpl_resp), .cpl_data(w_cpl_data)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (cpl_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b exp=0", cpl_valid); end
        checks++; if (cpl_last !== 1'b0) begin errs++; $display("FAIL rst_last got=%b exp=0", cpl_last); end
        checks++; if (cpl_id !== 8'd0) begin errs++; $display("FAIL rst_id got=%0d exp=0", cpl_id); end
        checks++; if (cpl_resp !== 2'b11) begin errs++; $display("FAIL rst_resp got=%0d exp=3", cpl_resp); end
        checks++; if (cpl_data !== 8'd0) begin errs++; $display("FAIL rst_data got=%0d exp=0", cpl_data); end
        checks++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        checks++; if (w_cpl_valid !== 1'b0 || w_req_ready !== 1'b1) begin
            errs++; $display("FAIL rst_wr got valid=%b ready=%b exp valid=0 ready=1", w_cpl_valid, w_req_ready);
        end
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        tick();
    endtask

    task automatic test_len3();
        req_valid = 1'b1; req_len = 8'd3; req_id = 8'd5; cpl_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errs++; $display("FAIL len3_accept got=%b exp=1", req_ready); end
        checks++; if (cpl_valid !== 1'b0) begin errs++; $display("FAIL len3_prevalid got=%b exp=0", cpl_valid); end
        tick();
        req_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            #1;
            checks++; if (cpl_valid !== 1'b1 || cpl_id !== 8'd5 || cpl_resp !== 2'b11 || cpl_data !== 8'd0) begin
                errs++; $display("FAIL len3_beat%0d got v=%b id=%0d resp=%0d data=%0d exp v=1 id=5 resp=3 data=0",
                                 b, cpl_valid, cpl_id, cpl_resp, cpl_data);
            end
            checks++; if (cpl_last !== (b == 3)) begin errs++; $display("FAIL len3_last%0d got=%b exp=%b", b, cpl_last, b == 3); end
            checks++; if (req_ready !== (b == 3)) begin errs++; $display("FAIL len3_ready%0d got=%b exp=%b", b, req_ready, b == 3); end
            tick();
        end
        checks++; if (cpl_valid !== 1'b0) begin errs++; $display("FAIL len3_end got=%b exp=0", cpl_valid); end
    endtask

    task automatic test_len0();
        req_valid = 1'b1; req_len = 8'd0; req_id = 8'd12; cpl_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (cpl_valid !== 1'b1 || cpl_last !== 1'b1 || cpl_id !== 8'd12) begin
            errs++; $display("FAIL len0_beat got v=%b l=%b id=%0d exp v=1 l=1 id=12", cpl_valid, cpl_last, cpl_id);
        end
        tick();
        checks++; if (cpl_valid !== 1'b0 || cpl_last !== 1'b0 || req_ready !== 1'b1) begin
            errs++; $display("FAIL len0_idle got v=%b l=%b rdy=%b exp v=0 l=0 rdy=1", cpl_valid, cpl_last, req_ready);
        end
    endtask

    task automatic test_len255_stall();
        int beats, cyc;
        logic stalled, p_last;
        logic [7:0] p_id;
        beats = 0; cyc = 0; stalled = 1'b0; p_last = 1'b0; p_id = '0;
        req_valid = 1'b1; req_len = 8'd255; req_id = 8'hA5; cpl_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        while (beats < 256 && cyc < 3000) begin
            cpl_ready = 1'($urandom_range(0, 1));
            #1;
            checks++; if (cpl_valid !== 1'b1) begin errs++; $display("FAIL l255_valid beat=%0d got=%b exp=1", beats, cpl_valid); end
            checks++; if (cpl_last !== (beats == 255)) begin
                errs++; $display("FAIL l255_last beat=%0d got=%b exp=%b", beats, cpl_last, beats == 255);
            end
            if (stalled) begin
                checks++; if (cpl_id !== p_id || cpl_last !== p_last) begin
                    errs++; $display("FAIL l255_hold got id=%0d l=%b exp id=%0d l=%b", cpl_id, cpl_last, p_id, p_last);
                end
            end
            stalled = !cpl_ready; p_id = cpl_id; p_last = cpl_last;
            if (cpl_ready) beats++;
            tick();
            cyc++;
        end
        cpl_ready = 1'b1;
        checks++; if (beats !== 256) begin errs++; $display("FAIL l255_count got=%0d exp=256", beats); end
        #1;
        checks++; if (cpl_valid !== 1'b0) begin errs++; $display("FAIL l255_end got=%b exp=0", cpl_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_id [5];
        logic       exp_last [5];
        logic       exp_rdy [5];
        exp_id   = '{8'd2, 8'd2, 8'd7, 8'd7, 8'd7};
        exp_last = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_rdy  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        req_valid = 1'b1; req_len = 8'd1; req_id = 8'd2; cpl_ready = 1'b1;
        tick();
        req_len = 8'd2; req_id = 8'd7;
        for (int k = 0; k < 5; k++) begin
            req_valid = (k <= 1);
            #1;
            checks++; if (cpl_valid !== 1'b1 || cpl_id !== exp_id[k] || cpl_last !== exp_last[k]) begin
                errs++; $display("FAIL b2b_beat%0d got v=%b id=%0d l=%b exp v=1 id=%0d l=%b",
                                 k, cpl_valid, cpl_id, cpl_last, exp_id[k], exp_last[k]);
            end
            checks++; if (req_ready !== exp_rdy[k]) begin
                errs++; $display("FAIL b2b_ready%0d got=%b exp=%b", k, req_ready, exp_rdy[k]);
            end
            tick();
        end
        req_valid = 1'b0;
        checks++; if (cpl_valid !== 1'b0) begin errs++; $display("FAIL b2b_end got=%b exp=0", cpl_valid); end
    endtask

    task automatic test_wr_path();
        w_req_valid = 1'b1; w_req_len = 8'hFF; w_req_id = 8'd9; cpl_ready = 1'b1;
        tick();
        w_req_valid = 1'b0;
        #1;
        checks++; if (w_cpl_valid !== 1'b1 || w_cpl_last !== 1'b1 || w_cpl_id !== 8'd9 || w_cpl_resp !== 2'b11) begin
            errs++; $display("FAIL wr_beat got v=%b l=%b id=%0d resp=%0d exp v=1 l=1 id=9 resp=3",
                             w_cpl_valid, w_cpl_last, w_cpl_id, w_cpl_resp);
        end
        checks++; if (w_req_ready !== 1'b1) begin errs++; $display("FAIL wr_ready got=%b exp=1", w_req_ready); end
        tick();
        checks++; if (w_cpl_valid !== 1'b0) begin errs++; $display("FAIL wr_end got=%b exp=0", w_cpl_valid); end
    endtask

    task automatic test_async_reset();
        req_valid = 1'b1; req_len = 8'd7; req_id = 8'd3; cpl_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checks++; if (cpl_valid !== 1'b1 || cpl_last !== 1'b0) begin
            errs++; $display("FAIL arst_pre got v=%b l=%b exp v=1 l=0", cpl_valid, cpl_last);
        end
        #2 aresetn = 1'b0;
        #1;
        checks++; if (cpl_valid !== 1'b0 || cpl_id !== 8'd0) begin
            errs++; $display("FAIL arst_imm got v=%b id=%0d exp v=0 id=0", cpl_valid, cpl_id);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (cpl_valid !== 1'b0 || req_ready !== 1'b1) begin
                errs++; $display("FAIL arst_after%0d got v=%b rdy=%b exp v=0 rdy=1", k, cpl_valid, req_ready);
            end
        end
    endtask

    task automatic test_srst();
        req_valid = 1'b1; req_len = 8'd4; req_id = 8'd6; cpl_ready = 1'b1;
        tick();
        req_valid = 1'b0; srst = 1'b1;
        #1;
        checks++; if (cpl_valid !== 1'b1 || cpl_id !== 8'd6) begin
            errs++; $display("FAIL srst_pre got v=%b id=%0d exp v=1 id=6", cpl_valid, cpl_id);
        end
        tick();
        srst = 1'b0;
        checks++; if (cpl_valid !== 1'b0 || cpl_id !== 8'd0 || req_ready !== 1'b1) begin
            errs++; $display("FAIL srst_post got v=%b id=%0d rdy=%b exp v=0 id=0 rdy=1", cpl_valid, cpl_id, req_ready);
        end
        tick();
        checks++; if (cpl_valid !== 1'b0) begin errs++; $display("FAIL srst_residual got=%b exp=0", cpl_valid); end
    endtask

    initial begin
        aresetn = 1'b0; srst = 1'b0; cpl_ready = 1'b0;
        req_valid = 1'b0; req_len = '0; req_id = '0;
        w_req_valid = 1'b0; w_req_len = '0; w_req_id = '0;
        test_reset();
        test_len3();
        test_len0();
        test_len255_stall();
        test_back_to_back();
        test_wr_path();
        test_async_reset();
        test_srst();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
